// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus: N masters, burst-aware
// grant holding, abort when the owner drops its request, and a watchdog
// that forces release when a granted burst stalls.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no owner; arbitrate among requesters on every edge
// S_OWN  | one master granted; count beats, watch for drop or stall
// S_TURN | single bus-turnaround cycle with grant low, no arbitration
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int BURST_W     = 13,
  parameter int SLAVE_SEL_W = 2,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic [NUM_MASTERS*BURST_W-1:0] m_burst_num,
  input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0] m_slave_sel,
  input  logic                           beat_done,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           bus_busy,
  output logic [SLAVE_SEL_W-1:0]         slave_sel,
  output logic [BURST_W-1:0]             beats_left,
  output logic [NUM_MASTERS-1:0]         tx_done,
  output logic                           abort,
  output logic                           timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_t                  state_q;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [IDX_W-1:0]        grant_idx_q;
  logic [IDX_W-1:0]        ptr_q;
  logic                    busy_q;
  logic [SLAVE_SEL_W-1:0]  slave_sel_q;
  logic [BURST_W-1:0]      beats_left_q;
  logic [NUM_MASTERS-1:0]  tx_done_q;
  logic                    abort_q;
  logic                    timeout_err_q;
  logic [15:0]             wdog_q;

  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;

  // Pick the first requester scanning upward from the slot after the last owner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!arb_found && m_req[(int'(ptr_q) + i) % NUM_MASTERS]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(ptr_q) + i) % NUM_MASTERS);
      end
    end
  end

  // Ownership FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      ptr_q         <= IDX_W'(NUM_MASTERS - 1);
      busy_q        <= 1'b0;
      slave_sel_q   <= '0;
      beats_left_q  <= '0;
      tx_done_q     <= '0;
      abort_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      tx_done_q     <= '0;
      abort_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            state_q      <= S_OWN;
            grant_q      <= ONE_HOT0 << arb_idx;
            grant_idx_q  <= arb_idx;
            ptr_q        <= arb_idx;
            busy_q       <= 1'b1;
            slave_sel_q  <= m_slave_sel[arb_idx*SLAVE_SEL_W +: SLAVE_SEL_W];
            beats_left_q <= m_burst_num[arb_idx*BURST_W +: BURST_W];
            wdog_q       <= '0;
          end
        end
        S_OWN: begin
          // Final beat beats a simultaneous request drop.
          if (beat_done && (beats_left_q == '0)) begin
            tx_done_q <= grant_q;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_TURN;
          end else if (!m_req[grant_idx_q]) begin
            abort_q   <= 1'b1;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_TURN;
          end else if (beat_done) begin
            beats_left_q <= beats_left_q - BURST_W'(1);
            wdog_q       <= '0;
          end else if ((wdog_q + 16'd1) == TO_CNT) begin
            timeout_err_q <= 1'b1;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            state_q       <= S_TURN;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        S_TURN:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign bus_busy    = busy_q;
  assign slave_sel   = slave_sel_q;
  assign beats_left  = beats_left_q;
  assign tx_done     = tx_done_q;
  assign abort       = abort_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: 4 masters, watchdog shortened to 8.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int BW = 13;
  localparam int SW = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    m_req;
  logic [N*BW-1:0] m_burst_num;
  logic [N*SW-1:0] m_slave_sel;
  logic            beat_done;
  logic [N-1:0]    grant;
  logic [1:0]      grant_idx;
  logic            bus_busy;
  logic [SW-1:0]   slave_sel;
  logic [BW-1:0]   beats_left;
  logic [N-1:0]    tx_done;
  logic            abort;
  logic            timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_rr #(.NUM_MASTERS(N), .BURST_W(BW), .SLAVE_SEL_W(SW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_burst_num(m_burst_num),
    .m_slave_sel(m_slave_sel), .beat_done(beat_done), .grant(grant),
    .grant_idx(grant_idx), .bus_busy(bus_busy), .slave_sel(slave_sel),
    .beats_left(beats_left), .tx_done(tx_done), .abort(abort),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_burst(input int m, input int v);
    m_burst_num[m*BW +: BW] = BW'(v);
  endtask

  task automatic set_sel(input int m, input int v);
    m_slave_sel[m*SW +: SW] = SW'(v);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(bus_busy), 0);
    chk({tag, "_tx"}, 32'(tx_done), 0);
    chk({tag, "_abort"}, 32'(abort), 0);
    chk({tag, "_tout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    reset = 1'b0; m_req = '0; m_burst_num = '0; m_slave_sel = '0; beat_done = 1'b0;

    // Reset
    tick(); tick();
    chk_idle_outs("rst");
    chk("rst_idx", 32'(grant_idx), 0);
    chk("rst_sel", 32'(slave_sel), 0);
    chk("rst_beats", 32'(beats_left), 0);

    // Single-beat transaction from master 2, request held to see spacing
    reset = 1'b1; m_req = 4'b0100; set_burst(2, 0); set_sel(2, 2);
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_idx", 32'(grant_idx), 2);
    chk("single_busy", 32'(bus_busy), 1);
    chk("single_sel", 32'(slave_sel), 2);
    chk("single_beats", 32'(beats_left), 0);
    beat_done = 1'b1;
    tick();
    chk("single_tx", 32'(tx_done), 32'b0100);
    chk("single_rel", 32'(grant), 0);
    chk("single_noabort", 32'(abort), 0);
    beat_done = 1'b0;
    tick();
    chk("single_turn_grant", 32'(grant), 0);
    chk("single_turn_tx", 32'(tx_done), 0);
    tick();
    chk("single_regrant", 32'(grant), 32'b0100);
    beat_done = 1'b1;
    tick();
    chk("single_tx2", 32'(tx_done), 32'b0100);
    beat_done = 1'b0; m_req = '0;
    tick(); tick();

    // Burst of 4 beats on master 1, beat every other cycle, burst input changed mid-way
    m_req = 4'b0010; set_burst(1, 3); set_sel(1, 1);
    tick();
    chk("burst_grant", 32'(grant), 32'b0010);
    chk("burst_sel", 32'(slave_sel), 1);
    chk("burst_b3", 32'(beats_left), 3);
    set_burst(1, 7); set_sel(1, 3);
    tick();
    chk("burst_gap_b3", 32'(beats_left), 3);
    beat_done = 1'b1; tick(); beat_done = 1'b0;
    chk("burst_b2", 32'(beats_left), 2);
    chk("burst_tx_b2", 32'(tx_done), 0);
    tick();
    beat_done = 1'b1; tick(); beat_done = 1'b0;
    chk("burst_b1", 32'(beats_left), 1);
    tick();
    beat_done = 1'b1; tick(); beat_done = 1'b0;
    chk("burst_b0", 32'(beats_left), 0);
    chk("burst_tx_b0", 32'(tx_done), 0);
    chk("burst_hold", 32'(grant), 32'b0010);
    chk("burst_sel_kept", 32'(slave_sel), 1);
    tick();
    beat_done = 1'b1; tick(); beat_done = 1'b0;
    chk("burst_tx", 32'(tx_done), 32'b0010);
    chk("burst_rel", 32'(grant), 0);
    m_req = '0;
    tick(); tick();

    // Round-robin from a fresh reset with all four requesting
    reset = 1'b0; tick();
    reset = 1'b1; m_req = 4'b1111;
    for (int m = 0; m < N; m++) set_burst(m, 0);
    beat_done = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_idx", k), 32'(grant_idx), 32'(k % 4));
      tick();
      chk($sformatf("rr%0d_tx", k), 32'(tx_done), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_turn", k), 32'(grant), 0);
    end
    m_req = '0; beat_done = 1'b0;
    tick();

    // Abort: master 3 drops request after 2 beats; master 0 waiting
    m_req = 4'b1001; set_burst(3, 5);
    tick();
    chk("abort_grant", 32'(grant), 32'b1000);
    chk("abort_b5", 32'(beats_left), 5);
    beat_done = 1'b1; tick(); tick(); beat_done = 1'b0;
    chk("abort_b3", 32'(beats_left), 3);
    m_req = 4'b0001;
    tick();
    chk("abort_pulse", 32'(abort), 1);
    chk("abort_notx", 32'(tx_done), 0);
    chk("abort_rel", 32'(grant), 0);
    tick();
    chk("abort_pulse_end", 32'(abort), 0);
    chk("abort_turn", 32'(grant), 0);
    tick();
    chk("abort_next", 32'(grant), 32'b0001);

    // Timeout: master 0 granted, no beats for 8 granted cycles
    for (int c = 1; c < 8; c++) begin
      tick();
      chk($sformatf("to_hold%0d", c), 32'(grant), 32'b0001);
      chk($sformatf("to_quiet%0d", c), 32'(timeout_err), 0);
    end
    set_burst(0, 2);
    tick();
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_rel", 32'(grant), 0);
    chk("to_noabort", 32'(abort), 0);
    tick();
    chk("to_pulse_end", 32'(timeout_err), 0);
    tick();
    chk("to_regrant", 32'(grant), 32'b0001);
    chk("to_regrant_b2", 32'(beats_left), 2);
    for (int c = 1; c < 8; c++) tick();
    chk("to_b_hold", 32'(grant), 32'b0001);
    beat_done = 1'b1;
    tick();
    beat_done = 1'b0;
    chk("to_beat_saves", 32'(timeout_err), 0);
    chk("to_beat_grant", 32'(grant), 32'b0001);
    chk("to_beat_b1", 32'(beats_left), 1);
    tick();
    chk("to_after_clear", 32'(timeout_err), 0);
    m_req = '0;
    tick();
    chk("to_drop_abort", 32'(abort), 1);
    tick(); tick();

    // Reset in the middle of a 5-beat burst
    m_req = 4'b0100; set_burst(2, 4);
    tick();
    chk("mrst_grant", 32'(grant), 32'b0100);
    beat_done = 1'b1;
    tick();
    chk("mrst_b3", 32'(beats_left), 3);
    reset = 1'b0;
    tick();
    chk_idle_outs("mrst");
    chk("mrst_beats", 32'(beats_left), 0);
    chk("mrst_idx", 32'(grant_idx), 0);
    chk("mrst_sel", 32'(slave_sel), 0);
    reset = 1'b1; beat_done = 1'b0; m_req = 4'b0101;
    tick();
    chk("mrst_prio0", 32'(grant), 32'b0001);
    chk("mrst_prio0_idx", 32'(grant_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
